// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back elastic stage.
package wb_pkg;

    localparam int DEF_DATA_W = 32;

    localparam int CH_INSTR = 0;
    localparam int CH_MEM   = 1;

    // Encoded as {skid_valid, main_valid}; 2'b10 would be a skid entry without a main entry.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } wb_state_t;

endpackage

// File: rtl/wb_data_reg.sv
// Payload register with load enable and synchronous clear; used for main and skid slots.
module wb_data_reg #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/wb_elastic_stage.sv
// Two-entry skid-buffered pipeline register between memory-access and write-back.
// Optional output-stall counter enabled by defining WB_STALL_CNT_EN.
module wb_elastic_stage
    import wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_CH   = 2
`ifdef WB_STALL_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic                   i_clk,
    input  logic                   i_s_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [N_CH*DATA_W-1:0] i_data,
    input  logic                   i_flush,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [N_CH*DATA_W-1:0] o_data
`ifdef WB_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]       o_stall_cnt
`endif
);

    localparam int W = N_CH * DATA_W;

    wb_state_t      state_q;
    wb_state_t      state_d;
    logic           main_v;
    logic           skid_v;
    logic           accept;
    logic           emit;
    logic           main_en;
    logic           skid_en;
    logic [W-1:0]   main_d;
    logic [W-1:0]   main_q;
    logic [W-1:0]   skid_q;

    assign main_v  = state_q[0];
    assign skid_v  = state_q[1];
    assign o_ready = ~skid_v;
    assign o_valid = main_v;
    assign o_data  = main_q;
    assign accept  = i_valid & o_ready;
    assign emit    = o_valid & i_ready;

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (accept) state_d = BUSY;
                BUSY: begin
                    if (accept && !emit) begin
                        state_d = FULL;
                    end else if (!accept && emit) begin
                        state_d = EMPTY;
                    end
                end
                FULL:    if (emit) state_d = BUSY;
                default: state_d = EMPTY;
            endcase
        end
    end

    // A flush suppresses every load, so both slots keep their stale contents.
    always_comb begin
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = i_data;
        if (!i_flush) begin
            case (state_q)
                EMPTY: main_en = accept;
                BUSY: begin
                    main_en = accept & emit;
                    skid_en = accept & ~emit;
                end
                FULL: begin
                    main_en = emit;
                    main_d  = skid_q;
                end
                default: ;
            endcase
        end
    end

    wb_data_reg #(.W(W)) u_main (
        .clk (i_clk),
        .rst (i_s_rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    wb_data_reg #(.W(W)) u_skid (
        .clk (i_clk),
        .rst (i_s_rst),
        .en  (skid_en),
        .d   (i_data),
        .q   (skid_q)
    );

    always_ff @(posedge i_clk) begin
        if (!i_s_rst) begin
            assert (!(skid_v && !main_v))
                else $error("wb_elastic_stage: skid valid without main valid");
        end
    end

`ifdef WB_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            stall_q <= '0;
        end else if (o_valid && !i_ready && stall_q != '1) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign o_stall_cnt = stall_q;
`endif

endmodule
